// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Multi-cycle sequencer for the register-file/ALU datapath. Each instruction
// is fetched over a ready-handshaked instruction-memory port into an
// instruction register. It then steps through DECODE, EXEC and WB while the
// controller drives the datapath control lines. Slow memory is handled by
// waiting in FETCH. A pause request (hold) parks the sequencer between
// instructions, and a dedicated halt word stops it until reset.
//
// Ports:
//   clk          in   1         single clock, rising-edge active
//   reset        in   1         synchronous, active-high reset
//   imem_req     out  1         fetch request, high only in FETCH
//   imem_addr    out  PC_WIDTH  fetch address, equals pc
//   imem_ready   in   1         imem_rdata valid this cycle
//   imem_rdata   in   32        fetched instruction word
//   hold         in   1         pause request, sampled at end of WB and in PAUSE
//   ir           out  32        latched instruction
//   alu_op       out  4         {ir[5], ir[2:0]}
//   opb_sel      out  1         ir[5], selects shift-amount extension as operand B
//   wb_sel       out  1         ir[31], selects 21-bit immediate as write-back data
//   rf_we        out  1         register-file write enable, one cycle per instruction
//   pc           out  PC_WIDTH  current program counter
//   instr_count  out  16        retired-instruction counter (wraps)
//   busy         out  1         high in FETCH, DECODE, EXEC, WB
//   halted       out  1         high in HALT
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int unsigned          PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
    parameter logic [PC_WIDTH-1:0]  PC_STEP   = PC_WIDTH'(4),
    parameter logic [31:0]          HALT_CODE = 32'hFFFF_FFFF
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_req,
    output logic [PC_WIDTH-1:0]  imem_addr,
    input  logic                 imem_ready,
    input  logic [31:0]          imem_rdata,
    input  logic                 hold,
    output logic [31:0]          ir,
    output logic [3:0]           alu_op,
    output logic                 opb_sel,
    output logic                 wb_sel,
    output logic                 rf_we,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [15:0]          instr_count,
    output logic                 busy,
    output logic                 halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_PAUSE,
        S_HALT
    } state_t;

    state_t state;
    state_t state_next;

    // -------------------------------------------------------------------------
    // State register and architectural registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Reset wins over everything, including a WB cycle: pc returns to
            // RESET_PC instead of incrementing and any pending fetch is dropped.
            state       <= S_IDLE;
            pc          <= RESET_PC;
            ir          <= '0;
            instr_count <= '0;
        end else begin
            state <= state_next;

            // ir reloads only on the fetch handshake; ready in any other
            // state is ignored so the decode fields stay stable until WB ends.
            if (state == S_FETCH && imem_ready) begin
                ir <= imem_rdata;
            end

            // Retirement: pc and counter advance on the same edge that
            // commits the register-file write.
            if (state == S_WB) begin
                pc          <= pc + PC_STEP;
                instr_count <= instr_count + 16'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assigned first covers every path through the case,
    // so no latch is inferred for state_next.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH:  if (imem_ready) state_next = S_DECODE;
            S_DECODE: state_next = (ir == HALT_CODE) ? S_HALT : S_EXEC;
            S_EXEC:   state_next = S_WB;
            S_WB:     state_next = hold ? S_PAUSE : S_FETCH;
            S_PAUSE:  if (!hold) state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs: state-derived strobes and ir-derived decode fields
    // -------------------------------------------------------------------------
    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;
    assign rf_we     = (state == S_WB);
    assign busy      = (state == S_FETCH) || (state == S_DECODE) ||
                       (state == S_EXEC)  || (state == S_WB);
    assign halted    = (state == S_HALT);

    assign alu_op  = {ir[5], ir[2:0]};
    assign opb_sel = ir[5];
    assign wb_sel  = ir[31];

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Self-checking bench for multicycle_controller. A cycle-by-cycle vector table
// covers reset exit, three zero-wait instructions and the decode fields.
// Hand-written sequences cover wait states, halt, hold/pause and reset taken
// mid-fetch and mid-WB. Outputs are checked at the falling edge, and inputs
// are driven there too.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam logic [31:0] I1   = 32'h8000_0025;  // wb_sel=1 opb_sel=1 alu_op=1101
    localparam logic [31:0] I2   = 32'h0000_0002;  // wb_sel=0 opb_sel=0 alu_op=0010
    localparam logic [31:0] I3   = 32'h0000_0013;  // wb_sel=0 opb_sel=0 alu_op=0011
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        hold;
    logic [31:0] ir;
    logic [3:0]  alu_op;
    logic        opb_sel;
    logic        wb_sel;
    logic        rf_we;
    logic [31:0] pc;
    logic [15:0] instr_count;
    logic        busy;
    logic        halted;

    multicycle_controller dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .hold        (hold),
        .ir          (ir),
        .alu_op      (alu_op),
        .opb_sel     (opb_sel),
        .wb_sel      (wb_sel),
        .rf_we       (rf_we),
        .pc          (pc),
        .instr_count (instr_count),
        .busy        (busy),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit auto_mem = 1'b0;
    logic [31:0] mem [16];

    typedef struct {
        logic        rdy;
        logic [31:0] rdata;
        logic        hld;
        logic        exp_req;
        logic        exp_we;
        logic        exp_busy;
        logic [31:0] exp_pc;
        logic [15:0] exp_cnt;
        logic [31:0] exp_ir;
        logic [3:0]  exp_alu;
        logic        exp_opb;
        logic        exp_wbs;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic rdy, input logic [31:0] rdata, input logic hld,
                                input logic req, input logic we, input logic bsy,
                                input logic [31:0] p, input logic [15:0] cnt,
                                input logic [31:0] i, input logic [3:0] alu,
                                input logic opb, input logic wbs);
        vec_t v;
        v.rdy = rdy;      v.rdata = rdata;  v.hld = hld;
        v.exp_req = req;  v.exp_we = we;    v.exp_busy = bsy;
        v.exp_pc = p;     v.exp_cnt = cnt;  v.exp_ir = i;
        v.exp_alu = alu;  v.exp_opb = opb;  v.exp_wbs = wbs;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock: optional memory model supplies the word at the current
    // address, then advance to the next falling edge.
    task automatic tick();
        if (auto_mem) imem_rdata = mem[imem_addr[5:2]];
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Leaves the bench at the falling edge of the IDLE cycle (cycle 1).
    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cyc   = 1;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req"},  32'(imem_req),    32'd0);
        check({tag, "_we"},   32'(rf_we),       32'd0);
        check({tag, "_busy"}, 32'(busy),        32'd0);
        check({tag, "_halt"}, 32'(halted),      32'd0);
        check({tag, "_pc"},   pc,               32'd0);
        check({tag, "_ir"},   ir,               32'd0);
        check({tag, "_cnt"},  32'(instr_count), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int we_cyc;
        int bad_req, bad_we, bad_pc, bad_cnt, bad_halt;

        reset      = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = '0;
        hold       = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = JUNK;

        //            rdy  rdata hld  req we bsy pc     cnt  ir    alu   opb wbs
        vecs[0]  = mk(1'b1, JUNK, 1'b0, 0, 0, 0, 32'd0,  16'd0, 32'd0, 4'h0, 0, 0); // IDLE
        vecs[1]  = mk(1'b1, I1,   1'b0, 1, 0, 1, 32'd0,  16'd0, 32'd0, 4'h0, 0, 0); // FETCH
        vecs[2]  = mk(1'b1, JUNK, 1'b0, 0, 0, 1, 32'd0,  16'd0, I1,    4'hD, 1, 1); // DECODE
        vecs[3]  = mk(1'b1, JUNK, 1'b1, 0, 0, 1, 32'd0,  16'd0, I1,    4'hD, 1, 1); // EXEC, stray hold
        vecs[4]  = mk(1'b1, JUNK, 1'b0, 0, 1, 1, 32'd0,  16'd0, I1,    4'hD, 1, 1); // WB
        vecs[5]  = mk(1'b1, I2,   1'b0, 1, 0, 1, 32'd4,  16'd1, I1,    4'hD, 1, 1); // FETCH
        vecs[6]  = mk(1'b1, JUNK, 1'b0, 0, 0, 1, 32'd4,  16'd1, I2,    4'h2, 0, 0);
        vecs[7]  = mk(1'b1, JUNK, 1'b0, 0, 0, 1, 32'd4,  16'd1, I2,    4'h2, 0, 0);
        vecs[8]  = mk(1'b1, JUNK, 1'b0, 0, 1, 1, 32'd4,  16'd1, I2,    4'h2, 0, 0);
        vecs[9]  = mk(1'b1, I3,   1'b0, 1, 0, 1, 32'd8,  16'd2, I2,    4'h2, 0, 0);
        vecs[10] = mk(1'b1, JUNK, 1'b0, 0, 0, 1, 32'd8,  16'd2, I3,    4'h3, 0, 0);
        vecs[11] = mk(1'b1, JUNK, 1'b0, 0, 0, 1, 32'd8,  16'd2, I3,    4'h3, 0, 0);
        vecs[12] = mk(1'b1, JUNK, 1'b0, 0, 1, 1, 32'd8,  16'd2, I3,    4'h3, 0, 0);
        vecs[13] = mk(1'b0, JUNK, 1'b0, 1, 0, 1, 32'd12, 16'd3, I3,    4'h3, 0, 0);

        // ---- Table: reset exit, zero-wait fetch, decode fields --------------
        auto_mem = 1'b0;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            check($sformatf("v%0d_req", i),  32'(imem_req),    32'(vecs[i].exp_req));
            check($sformatf("v%0d_addr", i), imem_addr,        vecs[i].exp_pc);
            check($sformatf("v%0d_we", i),   32'(rf_we),       32'(vecs[i].exp_we));
            check($sformatf("v%0d_busy", i), 32'(busy),        32'(vecs[i].exp_busy));
            check($sformatf("v%0d_halt", i), 32'(halted),      32'd0);
            check($sformatf("v%0d_pc", i),   pc,               vecs[i].exp_pc);
            check($sformatf("v%0d_cnt", i),  32'(instr_count), 32'(vecs[i].exp_cnt));
            check($sformatf("v%0d_ir", i),   ir,               vecs[i].exp_ir);
            check($sformatf("v%0d_alu", i),  32'(alu_op),      32'(vecs[i].exp_alu));
            check($sformatf("v%0d_opb", i),  32'(opb_sel),     32'(vecs[i].exp_opb));
            check($sformatf("v%0d_wbs", i),  32'(wb_sel),      32'(vecs[i].exp_wbs));
            imem_ready = vecs[i].rdy;
            imem_rdata = vecs[i].rdata;
            hold       = vecs[i].hld;
            tick();
        end
        hold = 1'b0;

        // ---- Wait states on the second fetch ---------------------------------
        auto_mem   = 1'b1;
        mem[0]     = I2;
        mem[1]     = I1;
        imem_ready = 1'b1;
        do_reset();
        run_to(6);                       // FETCH of second instruction, pc=4
        for (int k = 0; k < 4; k++) begin
            check($sformatf("wait%0d_req", k),  32'(imem_req), 32'd1);
            check($sformatf("wait%0d_addr", k), imem_addr,     32'd4);
            check($sformatf("wait%0d_ir", k),   ir,            I2);
            imem_ready = (k == 3);
            tick();
        end
        check("wait_decode_req", 32'(imem_req), 32'd0);
        check("wait_decode_ir",  ir,            I1);
        we_cyc = -1;
        for (int k = 0; k < 10 && we_cyc < 0; k++) begin
            if (rf_we) we_cyc = cyc;
            else tick();
        end
        check("wait_we_cycle", 32'(we_cyc), 32'd12);
        check("wait_we_pc",    pc,          32'd4);

        // ---- Halt word fetched at pc=8 --------------------------------------
        mem[0] = I2;
        mem[1] = I3;
        mem[2] = HALT;
        imem_ready = 1'b1;
        do_reset();
        run_to(11);                      // DECODE of the halt word
        check("halt_dec_ir",     ir,           HALT);
        check("halt_dec_halted", 32'(halted),  32'd0);
        check("halt_dec_busy",   32'(busy),    32'd1);
        tick();
        check("halt_halted", 32'(halted),      32'd1);
        check("halt_busy",   32'(busy),        32'd0);
        check("halt_pc",     pc,               32'd8);
        check("halt_cnt",    32'(instr_count), 32'd2);
        bad_req = 0; bad_we = 0; bad_pc = 0; bad_cnt = 0; bad_halt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (imem_req !== 1'b0)        bad_req++;
            if (rf_we !== 1'b0)           bad_we++;
            if (pc !== 32'd8)             bad_pc++;
            if (instr_count !== 16'd2)    bad_cnt++;
            if (halted !== 1'b1)          bad_halt++;
        end
        check("halt_req_cycles",    32'(bad_req),  32'd0);
        check("halt_we_cycles",     32'(bad_we),   32'd0);
        check("halt_pc_cycles",     32'(bad_pc),   32'd0);
        check("halt_cnt_cycles",    32'(bad_cnt),  32'd0);
        check("halt_halted_cycles", 32'(bad_halt), 32'd0);

        // ---- Hold at WB, then a stray hold pulse mid-instruction --------------
        mem[0] = I2;
        mem[1] = I3;
        mem[2] = I1;
        do_reset();
        run_to(5);                       // WB of first instruction
        check("hold_wb_we", 32'(rf_we), 32'd1);
        hold = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("pause%0d_busy", k), 32'(busy),     32'd0);
            check($sformatf("pause%0d_req", k),  32'(imem_req), 32'd0);
            check($sformatf("pause%0d_we", k),   32'(rf_we),    32'd0);
            if (k == 4) hold = 1'b0;
            tick();
        end
        check("resume_req",  32'(imem_req), 32'd1);
        check("resume_addr", imem_addr,     32'd4);
        tick();                          // DECODE: hold pulse must be forgotten
        hold = 1'b1;
        tick();
        hold = 1'b0;
        run_to(14);                      // WB of second instruction
        check("pulse_wb_we", 32'(rf_we), 32'd1);
        tick();
        check("pulse_fetch_req",  32'(imem_req), 32'd1);
        check("pulse_fetch_addr", imem_addr,     32'd8);

        // ---- Reset during a stalled FETCH ------------------------------------
        mem[0] = I2;
        mem[1] = I3;
        do_reset();
        run_to(6);                       // FETCH at pc=4, instr_count=1, ir=I2
        imem_ready = 1'b0;
        check("rstf_pre_req", 32'(imem_req), 32'd1);
        check("rstf_pre_pc",  pc,            32'd4);
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        imem_ready = 1'b1;
        check_reset_state("rstf");
        tick();
        check("rstf_refetch_req",  32'(imem_req), 32'd1);
        check("rstf_refetch_addr", imem_addr,     32'd0);

        // ---- Reset during WB --------------------------------------------------
        do_reset();
        run_to(9);                       // WB of second instruction
        check("rstw_pre_we", 32'(rf_we), 32'd1);
        check("rstw_pre_pc", pc,         32'd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("rstw");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
